keypad_scanner: RTL and testbench
=================================

Name: keypad_scanner

Overview:
- Input-side counterpart of the multiplexed seven-segment display driver.
- Scans a 4x4 matrix keypad (Pmod KYPD) one column at a time and synchronizes and debounces the row returns.
- Emits one pulse per debounced keypress and accumulates hex digits into a 32-bit value plus an active-low digit-enable mask that feed the display timer's DIGITS/EN inputs directly.

Parameters:
- SCAN_DIV, 50000: clk cycles per column dwell (>=2); prescaler width $clog2(SCAN_DIV).
- DEBOUNCE, 4: consecutive identical full scans required for press and for release (1..15).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- ROW  in  4  keypad rows, active-low (pulled up), asynchronous to clk
- CLR  in  1  synchronous clear of accumulator, active-high
- COL  out  4  column drive, active-low, exactly one bit low
- KEYCODE  out  4  hex value of last debounced key
- KEY_VALID  out  1  one-cycle pulse per debounced press
- KEY_HELD  out  1  high while debounced key is held
- DIGITS  out  32  accumulated digits, newest in [3:0]
- EN  out  8  digit enables, active-low, bit i low = digit i entered

Behaviour:
- Clocking: one clock; reset is asynchronous and active-high. All state resets together, including on reset mid-scan.
- Reset values:
  - COL=4'b1110 (column 0)
  - KEYCODE=0, KEY_VALID=0, KEY_HELD=0
  - DIGITS=0, EN=8'hff
  - prescaler=0, column index=0, FSM=IDLE, counters=0
- Synchronizer: ROW passes through a 2-flop synchronizer before any use.
- Prescaler:
  - Counts 0..SCAN_DIV-1 and wraps.
  - tick is asserted when the count equals SCAN_DIV-1.
- On tick:
  - The synchronized ROW is sampled into a 16-bit snapshot for the current column (bit = row*4+col, 1 = pressed).
  - The column index then increments mod 4, and COL = ~(1<<index).
- Scan completion: the tick with index==3 completes a scan. The decoder and FSM evaluate the completed snapshot on the next clk edge (scan_done).
- Decode:
  - Exactly one bit set -> single key k. Zero bits -> none. Two or more -> multi.
  - Key map by row (col0..col3):
    - row0: 1 2 3 A
    - row1: 4 5 6 B
    - row2: 7 8 9 C
    - row3: 0 F E D
- FSM, evaluated only on scan_done:
  - IDLE:
    - single k -> CAND, cand=k, cnt=1.
    - If DEBOUNCE==1, go directly to PRESSED and emit the press.
    - none or multi -> stay.
  - CAND:
    - single == cand -> cnt+1.
    - When cnt reaches DEBOUNCE -> PRESSED, KEYCODE=cand, KEY_VALID=1 for one cycle, KEY_HELD=1.
    - Different key, none, or multi -> IDLE, cnt=0.
  - PRESSED:
    - none -> rcnt+1; when rcnt reaches DEBOUNCE -> IDLE, KEY_HELD=0.
    - single or multi -> rcnt=0, stay. No further pulses while held.
- Latency: a clean steady press emits KEY_VALID 1 cycle after the scan_done of the DEBOUNCE-th matching scan. Worst case is (DEBOUNCE+1)*4*SCAN_DIV+3 cycles from ROW change.
- Accumulator:
  - On the KEY_VALID cycle: DIGITS <= {DIGITS[27:0], KEYCODE}; EN <= {EN[6:0],1'b0}. The oldest digit is discarded after 8 entries, and EN saturates at 8'h00.
  - CLR: DIGITS=0, EN=8'hff. CLR has priority over a simultaneous KEY_VALID, and the key is dropped from the accumulator; KEYCODE still updates.
- Key press during CLR: does not affect scan or FSM state.

Test Plan:
Common configuration for all scenarios: SCAN_DIV=4, DEBOUNCE=3.
- Reset then idle 200 cycles -> COL cycles 1110,1101,1011,0111 every 4 cycles; KEY_VALID never high; DIGITS=0, EN=8'hff.
- Hold key "5" steadily: ROW[1] low whenever COL=1101 -> exactly one KEY_VALID pulse, KEYCODE=4'h5, DIGITS=32'h00000005, EN=8'hfe, KEY_HELD=1. Continue holding for 50 scans -> no second pulse. Release for 3 scans -> KEY_HELD=0.
- Bounce: "5" present 2 scans, absent 1, present 2 -> no KEY_VALID.
- Press "3" and "A" together (ROW[0] low on COL 1011 and 0111) for 10 scans -> no KEY_VALID.
- Sequence 1,2,3,4,5,6,7,8,9,D, each cleanly pressed and released -> DIGITS=32'h3456789D, EN=8'h00.
- Combined CLR and reset:
  - Assert CLR on the same cycle as KEY_VALID for key "E" -> DIGITS=0, EN=8'hff, KEYCODE=4'hE.
  - Assert reset mid-CAND -> all outputs return to reset values immediately.
  - A press completed after reset is detected normally.

Source files
------------

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 matrix keypad one column at a time and debounces
// whole-keypad snapshots. Each debounced press produces a one-cycle KEY_VALID
// pulse and is shifted into an 8-digit hex accumulator, which drives the
// display's DIGITS/EN inputs.
module keypad_scanner #(
  parameter int SCAN_DIV = 50000,  // clk cycles per column dwell (>= 2)
  parameter int DEBOUNCE = 4       // identical full scans needed for press/release (1..15)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  ROW,
  input  logic        CLR,
  output logic [3:0]  COL,
  output logic [3:0]  KEYCODE,
  output logic        KEY_VALID,
  output logic        KEY_HELD,
  output logic [31:0] DIGITS,
  output logic [7:0]  EN
);

  localparam int            PW        = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
  localparam logic [3:0]    DEB       = 4'(DEBOUNCE);

  typedef enum logic [1:0] {IDLE, CAND, PRESSED} state_t;

  logic [3:0]    row_meta, row_sync;
  logic [PW-1:0] presc;
  logic          tick;
  logic [1:0]    col_idx;
  logic [15:0]   snap;       // bit {row,col} = 1 when that key was seen pressed
  logic          scan_done;
  logic [4:0]    hits;
  logic [3:0]    hit_pos;
  logic [3:0]    hit_code;
  logic          single, none;
  state_t        state;
  logic [3:0]    cand;
  logic [3:0]    cnt, rcnt;

  // Physical key position {row,col} to the hex value printed on the key.
  function automatic logic [3:0] key_map(input logic [3:0] pos);
    case (pos)
      4'd0:    return 4'h1;
      4'd1:    return 4'h2;
      4'd2:    return 4'h3;
      4'd3:    return 4'hA;
      4'd4:    return 4'h4;
      4'd5:    return 4'h5;
      4'd6:    return 4'h6;
      4'd7:    return 4'hB;
      4'd8:    return 4'h7;
      4'd9:    return 4'h8;
      4'd10:   return 4'h9;
      4'd11:   return 4'hC;
      4'd12:   return 4'h0;
      4'd13:   return 4'hF;
      4'd14:   return 4'hE;
      default: return 4'hD;
    endcase
  endfunction

  // Two-flop synchronizer for the asynchronous row returns; idle rows read high.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values, independent of statement order.
    if (reset) begin
      row_meta <= '1;
      row_sync <= '1;
    end else begin
      row_meta <= ROW;
      row_sync <= row_meta;
    end
  end

  assign tick = (presc == PRESC_MAX);

  // Column dwell prescaler, column stepping and per-column snapshot capture.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: the 16-bit snapshot is a plain register, not a RAM, so it is reset
    // along with everything else; a mid-scan reset leaves no stale key bits.
    if (reset) begin
      presc     <= '0;
      col_idx   <= 2'd0;
      snap      <= '0;
      scan_done <= 1'b0;
    end else begin
      scan_done <= tick && (col_idx == 2'd3);
      if (tick) begin
        presc   <= '0;
        col_idx <= col_idx + 2'd1;
        for (int r = 0; r < 4; r++) begin
          snap[{2'(r), col_idx}] <= ~row_sync[r];
        end
      end else begin
        presc <= presc + PW'(1);
      end
    end
  end

  assign COL = ~(4'b0001 << col_idx);

  // Classify the completed snapshot: number of keys down and the last one found.
  always_comb begin
    // NOTE: defaults first so no path leaves a variable unassigned (no latch).
    hits    = 5'd0;
    hit_pos = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (snap[i]) begin
        hits    = hits + 5'd1;
        hit_pos = 4'(i);
      end
    end
  end

  assign single   = (hits == 5'd1);
  assign none     = (hits == 5'd0);
  assign hit_code = key_map(hit_pos);

  // Debounce FSM, advanced once per completed scan; outputs are registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cand      <= 4'd0;
      cnt       <= 4'd0;
      rcnt      <= 4'd0;
      KEYCODE   <= 4'd0;
      KEY_VALID <= 1'b0;
      KEY_HELD  <= 1'b0;
    end else begin
      KEY_VALID <= 1'b0;
      if (scan_done) begin
        unique case (state)
          IDLE: begin
            if (single) begin
              cand <= hit_code;
              if (DEB == 4'd1) begin
                state     <= PRESSED;
                KEYCODE   <= hit_code;
                KEY_VALID <= 1'b1;
                KEY_HELD  <= 1'b1;
                cnt       <= 4'd0;
                rcnt      <= 4'd0;
              end else begin
                state <= CAND;
                cnt   <= 4'd1;
              end
            end
          end
          CAND: begin
            if (single && hit_code == cand) begin
              if (cnt + 4'd1 == DEB) begin
                state     <= PRESSED;
                KEYCODE   <= cand;
                KEY_VALID <= 1'b1;
                KEY_HELD  <= 1'b1;
                cnt       <= 4'd0;
                rcnt      <= 4'd0;
              end else begin
                cnt <= cnt + 4'd1;
              end
            end else begin
              // A different key, no key or several keys abandons the candidate.
              state <= IDLE;
              cnt   <= 4'd0;
            end
          end
          PRESSED: begin
            if (none) begin
              if (rcnt + 4'd1 == DEB) begin
                state    <= IDLE;
                KEY_HELD <= 1'b0;
                rcnt     <= 4'd0;
              end else begin
                rcnt <= rcnt + 4'd1;
              end
            end else begin
              rcnt <= 4'd0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Digit accumulator; CLR wins over a coincident keypress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      DIGITS <= 32'd0;
      EN     <= 8'hff;
    end else if (CLR) begin
      DIGITS <= 32'd0;
      EN     <= 8'hff;
    end else if (KEY_VALID) begin
      DIGITS <= {DIGITS[27:0], KEYCODE};
      EN     <= {EN[6:0], 1'b0};
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Testbench for keypad_scanner: an ideal keypad model drives ROW from COL, the
// stimulus applies one key set per full scan, a scan-level reference model
// predicts presses and accumulator contents, and a monitor checks each pulse.
module tb_keypad_scanner;

  localparam int SCAN_DIV = 4;
  localparam int DEBOUNCE = 3;
  localparam int SCAN_CYC = 4 * SCAN_DIV;

  localparam logic [3:0] KEY_AT [16] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'h0, 4'hF, 4'hE, 4'hD
  };

  typedef struct {
    logic [3:0]  code;
    logic [31:0] digits;
    logic [7:0]  en;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  ROW;
  logic        CLR;
  logic [3:0]  COL;
  logic [3:0]  KEYCODE;
  logic        KEY_VALID;
  logic        KEY_HELD;
  logic [31:0] DIGITS;
  logic [7:0]  EN;

  logic [15:0] keys;  // physical keys held down, bit {row,col}

  int n_tests = 0;
  int n_fail  = 0;

  exp_t exp_q[$];

  // Reference model state (per-scan view of the keypad).
  bit          m_held;
  int          m_run;
  logic [3:0]  m_cand;
  int          m_none_run;
  bit          m_pend;
  logic [3:0]  m_pend_code;
  logic [31:0] m_digits;
  logic [7:0]  m_en;

  keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE)) dut (
    .clk       (clk),
    .reset     (reset),
    .ROW       (ROW),
    .CLR       (CLR),
    .COL       (COL),
    .KEYCODE   (KEYCODE),
    .KEY_VALID (KEY_VALID),
    .KEY_HELD  (KEY_HELD),
    .DIGITS    (DIGITS),
    .EN        (EN)
  );

  always #5 clk = ~clk;

  // Ideal matrix: a row is pulled low when a held key sits on the driven column.
  always_comb begin
    ROW = 4'hf;
    for (int r = 0; r < 4; r++) begin
      ROW[r] = ~|(keys[r*4 +: 4] & ~COL);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] pos_mask(input logic [3:0] code);
    logic [15:0] m;
    m = '0;
    for (int i = 0; i < 16; i++) begin
      if (KEY_AT[i] == code) m = 16'(1) << i;
    end
    return m;
  endfunction

  task automatic model_reset();
    m_held      = 0;
    m_run       = 0;
    m_cand      = 4'd0;
    m_none_run  = 0;
    m_pend      = 0;
    m_pend_code = 4'd0;
    m_digits    = 32'd0;
    m_en        = 8'hff;
    exp_q.delete();
  endtask

  // One completed scan seen by the keypad logic.
  task automatic model_scan(input logic [15:0] k);
    int         n;
    int         pos;
    logic [3:0] code;
    n   = $countones(k);
    pos = 0;
    for (int i = 0; i < 16; i++) if (k[i]) pos = i;
    code = KEY_AT[pos];
    if (m_held) begin
      // Held: only DEBOUNCE consecutive empty scans release the key.
      if (n == 0) begin
        m_none_run++;
        if (m_none_run == DEBOUNCE) begin
          m_held     = 0;
          m_none_run = 0;
        end
      end else begin
        m_none_run = 0;
      end
    end else if (n == 1) begin
      if (m_run > 0 && code != m_cand) begin
        // Switching keys abandons the candidate; the new key starts next scan.
        m_run = 0;
      end else begin
        if (m_run == 0) m_cand = code;
        m_run++;
        if (m_run == DEBOUNCE) begin
          m_held      = 1;
          m_run       = 0;
          m_none_run  = 0;
          m_pend      = 1;
          m_pend_code = code;
        end
      end
    end else begin
      m_run = 0;
    end
  endtask

  // The press predicted from the previous scan reaches the accumulator now,
  // together with an optional CLR on the same cycle.
  task automatic model_resolve(input bit clr);
    exp_t e;
    if (clr) begin
      m_digits = 32'd0;
      m_en     = 8'hff;
    end else if (m_pend) begin
      m_digits = {m_digits[27:0], m_pend_code};
      m_en     = {m_en[6:0], 1'b0};
    end
    if (m_pend) begin
      e.code   = m_pend_code;
      e.digits = m_digits;
      e.en     = m_en;
      exp_q.push_back(e);
    end
    m_pend = 0;
  endtask

  // Called at the first negedge of a scan: apply k for the whole scan.
  task automatic run_scan(input logic [15:0] k, input bit clr);
    check("col_at_scan_start", COL, 4'b1110);
    model_resolve(clr);
    keys = k;
    @(negedge clk);
    if (clr) CLR = 1'b1;
    @(negedge clk);
    CLR = 1'b0;
    @(negedge clk);
    check("key_held", KEY_HELD, m_held);
    model_scan(k);
    repeat (SCAN_CYC - 3) @(negedge clk);
  endtask

  task automatic repeat_scan(input logic [15:0] k, input int n);
    for (int i = 0; i < n; i++) run_scan(k, 1'b0);
  endtask

  // Monitor: every KEY_VALID pulse must match the oldest predicted press.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (KEY_VALID === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_key_valid: got pulse keycode %0h expected none at %0t",
                   KEYCODE, $time);
        end else begin
          e = exp_q.pop_front();
          check("pulse_keycode", KEYCODE, e.code);
          @(negedge clk);
          check("pulse_key_valid_one_cycle", KEY_VALID, 1'b0);
          check("pulse_digits", DIGITS, e.digits);
          check("pulse_en", EN, e.en);
        end
      end
    end
  end

  initial begin
    logic [3:0]  exp_col;
    logic [15:0] k;
    logic [3:0]  seq [10];
    int          kind;
    int          len;

    seq = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hD};

    reset = 1'b1;
    CLR   = 1'b0;
    keys  = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_col", COL, 4'b1110);
    check("reset_digits", DIGITS, 32'd0);
    check("reset_en", EN, 8'hff);
    reset = 1'b0;

    // Idle: column walk and no pulses.
    for (int n = 0; n < 13 * SCAN_CYC; n++) begin
      exp_col = ~(4'b0001 << ((n / SCAN_DIV) % 4));
      check("idle_col", COL, exp_col);
      check("idle_no_valid", KEY_VALID, 1'b0);
      @(negedge clk);
    end
    check("idle_digits", DIGITS, 32'd0);
    check("idle_en", EN, 8'hff);

    // Steady hold of "5", then release.
    repeat_scan(pos_mask(4'h5), 4);
    check("hold5_keycode", KEYCODE, 4'h5);
    check("hold5_digits", DIGITS, 32'h00000005);
    check("hold5_en", EN, 8'hfe);
    check("hold5_held", KEY_HELD, 1'b1);
    repeat_scan(pos_mask(4'h5), 49);
    repeat_scan('0, 4);
    check("release5_held", KEY_HELD, 1'b0);

    // Bounce: 2 present, 1 absent, 2 present.
    repeat_scan(pos_mask(4'h5), 2);
    repeat_scan('0, 1);
    repeat_scan(pos_mask(4'h5), 2);
    repeat_scan('0, 4);

    // "3" and "A" together.
    repeat_scan(pos_mask(4'h3) | pos_mask(4'hA), 10);
    repeat_scan('0, 4);
    check("after_bounce_multi_digits", DIGITS, 32'h00000005);

    // Randomized scan patterns with occasional CLR.
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 9);
      len  = $urandom_range(1, 6);
      if (kind < 4)      k = '0;
      else if (kind < 9) k = 16'(1) << $urandom_range(0, 15);
      else               k = (16'(1) << $urandom_range(0, 15)) | (16'(1) << $urandom_range(0, 15));
      for (int j = 0; j < len; j++) run_scan(k, $urandom_range(0, 7) == 0);
    end
    repeat_scan('0, 4);
    check("random_digits", DIGITS, m_digits);
    check("random_en", EN, m_en);

    // CLR coincident with the KEY_VALID of "E".
    repeat_scan(pos_mask(4'hE), 3);
    run_scan('0, 1'b1);
    check("clr_digits", DIGITS, 32'd0);
    check("clr_en", EN, 8'hff);
    check("clr_keycode", KEYCODE, 4'hE);
    repeat_scan('0, 3);

    // Ten clean presses: oldest two digits fall off, all enables on.
    for (int i = 0; i < 10; i++) begin
      repeat_scan(pos_mask(seq[i]), 3);
      repeat_scan('0, 3);
    end
    check("seq_digits", DIGITS, 32'h3456789D);
    check("seq_en", EN, 8'h00);

    // Reset while a candidate "7" is being debounced.
    repeat_scan(pos_mask(4'h7), 2);
    check("cand_col", COL, 4'b1110);
    keys = pos_mask(4'h7);
    repeat (5) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("midrst_col", COL, 4'b1110);
    check("midrst_keycode", KEYCODE, 4'h0);
    check("midrst_valid", KEY_VALID, 1'b0);
    check("midrst_held", KEY_HELD, 1'b0);
    check("midrst_digits", DIGITS, 32'd0);
    check("midrst_en", EN, 8'hff);
    model_reset();
    keys = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // A full press after reset is detected normally.
    repeat_scan(pos_mask(4'h7), 3);
    repeat_scan('0, 4);
    check("post_reset_keycode", KEYCODE, 4'h7);
    check("post_reset_digits", DIGITS, 32'h00000007);
    check("post_reset_en", EN, 8'hfe);

    check("no_missing_pulses", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
